i2c_bus_monitor: RTL and testbench
==================================

# i2c_bus_monitor

Parametrised I2C bus-condition monitor for slave-side front ends. It synchronises and glitch-filters raw SDA/SCL, detects START, repeated START and STOP, tracks bus-busy state, and deserialises each byte plus its ACK bit. An idle-SCL timeout recovers from a hung bus. It sits between the pads and the slave address/register logic, which consumes its pulses and bytes.

## Interface
Parameters:
- SYNC_STAGES, 2: flip-flop synchroniser depth per input, ≥2.
- FILTER_CYCLES, 3: consecutive equal synchronised samples required before a filtered line changes, ≥1.
- TIMEOUT_CYCLES, 1024: clk cycles without a filtered SCL edge while busy before forced release, ≥2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- sdin  in  1  raw SDA, asynchronous to clk.
- sclk  in  1  raw SCL, asynchronous to clk.
- start_detect  out  1  one-cycle pulse, START from idle.
- rstart_detect  out  1  one-cycle pulse, START while busy (repeated START).
- stop_detect  out  1  one-cycle pulse, STOP.
- bus_busy  out  1  level, high from START until STOP or timeout.
- byte_valid  out  1  one-cycle pulse, byte_data updated.
- byte_data  out  8  last complete byte, MSB first on the wire.
- ack_valid  out  1  one-cycle pulse, ack_bit updated.
- ack_bit  out  1  SDA sampled on 9th SCL rise (0 = ACK).
- timeout  out  1  one-cycle pulse, busy bus released by timeout.

## Operation
- Synchroniser: SYNC_STAGES registers per line, reset to 1.
- Filter: per line, a counter of consecutive cycles where the synchronised value differs from the filtered value. The filtered value takes the new value when the count reaches FILTER_CYCLES; the count clears on any agreeing sample. Filtered lines reset to 1.
- Edge registers hold the previous filtered SDA/SCL, reset to 1.
- Conditions are evaluated on filtered values each cycle:
  - START: SCL prev=1, SCL now=1, SDA 1→0.
  - STOP: SCL prev=1, SCL now=1, SDA 1→0 reversed, i.e. SDA 0→1.
  - If SCL and SDA change in the same cycle, neither START nor STOP is detected, and the SCL edge is processed normally.
- FSM states:
  - IDLE:
    - START → start_detect, go to BUSY, bit_cnt=0.
    - SCL edges are ignored.
    - STOP produces stop_detect and stays in IDLE.
  - BUSY:
    - START → rstart_detect, bit_cnt=0, partial byte discarded.
    - STOP → stop_detect, go to IDLE, partial byte discarded.
    - SCL rise with bit_cnt 0..7 → shift SDA into the shift register (MSB first), bit_cnt+1. When bit_cnt becomes 8, load byte_data and pulse byte_valid.
    - SCL rise with bit_cnt=8 → ack_bit=SDA, pulse ack_valid, bit_cnt=0.
- bit_cnt is 4 bits and wraps only via the ACK rule above.
- Timeout: the counter clears on every filtered SCL edge, on entering BUSY, and in IDLE. In BUSY, when it reaches TIMEOUT_CYCLES−1: pulse timeout, go to IDLE, bit_cnt=0. START/STOP in the same cycle take priority and the timeout is suppressed.
- bus_busy = (state==BUSY), registered.
- Reset (any time, including mid-byte): all pulses 0, bus_busy 0, byte_data 0x00, ack_bit 1, bit_cnt 0, state IDLE, counters 0.

## Timing
- All outputs are registered.
- Latency: a raw input change first sampled at clk edge N reaches the filtered value at edge N+SYNC_STAGES+FILTER_CYCLES−1. The resulting pulse or byte update is visible after edge N+SYNC_STAGES+FILTER_CYCLES. With defaults this is 5 cycles.
- Every pulse is high for exactly one cycle. At most one of start_detect, rstart_detect, stop_detect or timeout fires per cycle.
- byte_valid and ack_valid never coincide with each other.
- Glitches shorter than FILTER_CYCLES cycles after synchronisation produce no filtered change and no event.
- No backpressure: the consumer must accept byte_valid in the same cycle.

## Test plan
- Reset then idle high lines: all outputs 0, ack_bit 1. Hold 20 cycles: no pulses.
- START, byte 0xA5, ACK=0, STOP, each bus phase held 10 clk: start_detect, bus_busy=1, byte_valid with byte_data=0xA5, ack_valid with ack_bit=0, stop_detect, bus_busy=0. Check each pulse is 1 cycle at 5-cycle latency.
- START, 4 bits, repeated START, byte 0x3C, NACK: rstart_detect once, no byte_valid for the partial byte, then byte_data=0x3C, ack_bit=1.
- 2-cycle SDA low glitch with SCL high while idle (FILTER_CYCLES=3): no start_detect. A 3-cycle glitch produces start_detect followed by stop_detect.
- START then SCL held low for TIMEOUT_CYCLES=16 cycles: timeout pulse, bus_busy=0. A subsequent START gives start_detect, not rstart_detect.
- Assert reset mid-byte after 5 bits, release, send START plus 0xFF: byte_data=0xFF with no stale bits. SCL and SDA toggled in the same cycle produce neither START nor STOP.

Source files
------------

// File: rtl/i2c_bus_monitor.sv
// I2C bus-condition monitor: synchronises and glitch-filters SDA/SCL, detects START/STOP,
// tracks bus-busy and deserialises bytes plus their ACK bit, with an idle-SCL timeout.
module i2c_bus_monitor #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_CYCLES  = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sdin,
  input  logic       sclk,
  output logic       start_detect,
  output logic       rstart_detect,
  output logic       stop_detect,
  output logic       bus_busy,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       ack_valid,
  output logic       ack_bit,
  output logic       timeout
);

  localparam int unsigned FW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [FW-1:0] FiltMax = FW'(FILTER_CYCLES - 1);
  localparam logic [TW-1:0] ToMax   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {StIdle, StBusy} state_e;

  // Line index 0 is SDA, index 1 is SCL.
  logic [1:0]                  raw;
  logic [1:0][SYNC_STAGES-1:0] sync_q;
  logic [1:0][FW-1:0]          fcnt_q;
  logic [1:0]                  filt_q;
  logic [1:0]                  prev_q;

  assign raw = {sclk, sdin};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '1;
      fcnt_q <= '0;
      filt_q <= '1;
      prev_q <= '1;
    end else begin
      prev_q <= filt_q;
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
        if (sync_q[i][SYNC_STAGES-1] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == FiltMax) begin
          filt_q[i] <= sync_q[i][SYNC_STAGES-1];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + FW'(1);
        end
      end
    end
  end

  logic sda_now, sda_prev, scl_now, scl_prev;
  logic start_cond, stop_cond, scl_edge, scl_rise;

  assign sda_now  = filt_q[0];
  assign sda_prev = prev_q[0];
  assign scl_now  = filt_q[1];
  assign scl_prev = prev_q[1];

  // SCL must be steady high across the SDA transition, so simultaneous changes never qualify.
  assign start_cond = scl_prev & scl_now & sda_prev & ~sda_now;
  assign stop_cond  = scl_prev & scl_now & ~sda_prev & sda_now;
  assign scl_edge   = scl_prev ^ scl_now;
  assign scl_rise   = ~scl_prev & scl_now;

  state_e        state_q;
  logic [3:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic [TW-1:0] to_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      to_cnt_q      <= '0;
      start_detect  <= 1'b0;
      rstart_detect <= 1'b0;
      stop_detect   <= 1'b0;
      bus_busy      <= 1'b0;
      byte_valid    <= 1'b0;
      byte_data     <= '0;
      ack_valid     <= 1'b0;
      ack_bit       <= 1'b1;
      timeout       <= 1'b0;
    end else begin
      start_detect  <= 1'b0;
      rstart_detect <= 1'b0;
      stop_detect   <= 1'b0;
      byte_valid    <= 1'b0;
      ack_valid     <= 1'b0;
      timeout       <= 1'b0;
      unique case (state_q)
        StIdle: begin
          to_cnt_q  <= '0;
          bit_cnt_q <= '0;
          if (start_cond) begin
            start_detect <= 1'b1;
            state_q      <= StBusy;
            bus_busy     <= 1'b1;
            shift_q      <= '0;
          end else if (stop_cond) begin
            stop_detect <= 1'b1;
          end
        end
        StBusy: begin
          if (start_cond) begin
            rstart_detect <= 1'b1;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            to_cnt_q      <= '0;
          end else if (stop_cond) begin
            stop_detect <= 1'b1;
            state_q     <= StIdle;
            bus_busy    <= 1'b0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
          end else if (scl_edge) begin
            to_cnt_q <= '0;
            if (scl_rise) begin
              if (bit_cnt_q == 4'd8) begin
                ack_bit   <= sda_now;
                ack_valid <= 1'b1;
                bit_cnt_q <= '0;
              end else begin
                shift_q   <= {shift_q[6:0], sda_now};
                bit_cnt_q <= bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'd7) begin
                  byte_data  <= {shift_q[6:0], sda_now};
                  byte_valid <= 1'b1;
                end
              end
            end
          end else if (to_cnt_q == ToMax) begin
            timeout   <= 1'b1;
            state_q   <= StIdle;
            bus_busy  <= 1'b0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            to_cnt_q  <= '0;
          end else begin
            to_cnt_q <= to_cnt_q + TW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Scoreboard bench for i2c_bus_monitor: a bus-phase level reference model predicts events
// and their arrival cycle; a negedge monitor pops and compares every pulse the DUT emits.
module tb_i2c_bus_monitor;

  localparam int unsigned SyncStages = 2;
  localparam int unsigned FiltCycles = 3;
  localparam int unsigned ToCycles   = 16;
  localparam int          Latency    = SyncStages + FiltCycles + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sdin = 1'b1;
  logic       sclk = 1'b1;
  logic       start_detect, rstart_detect, stop_detect, bus_busy;
  logic       byte_valid, ack_valid, ack_bit, timeout;
  logic [7:0] byte_data;

  i2c_bus_monitor #(
    .SYNC_STAGES   (SyncStages),
    .FILTER_CYCLES (FiltCycles),
    .TIMEOUT_CYCLES(ToCycles)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sdin         (sdin),
    .sclk         (sclk),
    .start_detect (start_detect),
    .rstart_detect(rstart_detect),
    .stop_detect  (stop_detect),
    .bus_busy     (bus_busy),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .ack_valid    (ack_valid),
    .ack_bit      (ack_bit),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {EvStart, EvRstart, EvStop, EvTimeout, EvByte, EvAck} ev_e;
  typedef struct {
    ev_e        kind;
    logic [7:0] data;
    logic       busy;
    int         at;   // -1: cycle not predicted
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   hl = 6;

  // Reference model state, in terms of settled bus levels.
  logic       m_scl = 1'b1, m_sda = 1'b1, m_busy = 1'b0;
  int         m_bits = 0, m_gap = 0;
  logic [7:0] m_shift = '0;

  task automatic push_ev(input ev_e k, input logic [7:0] d, input logic b, input int at);
    exp_t e;
    e.kind = k; e.data = d; e.busy = b; e.at = at;
    exp_q.push_back(e);
  endtask

  task automatic model_step(input logic s, input logic d, input int len, input int now);
    logic st, sp;
    if (len >= int'(FiltCycles) && (s != m_scl || d != m_sda)) begin
      st = m_scl && s && m_sda && !d;
      sp = m_scl && s && !m_sda && d;
      if (st) begin
        push_ev(m_busy ? EvRstart : EvStart, 8'h00, 1'b1, now + Latency);
        m_busy = 1'b1; m_bits = 0; m_gap = 0;
      end else if (sp) begin
        push_ev(EvStop, 8'h00, 1'b0, now + Latency);
        m_busy = 1'b0; m_bits = 0;
      end else begin
        if (s != m_scl) m_gap = 0;
        if (m_busy && !m_scl && s) begin
          if (m_bits < 8) begin
            m_shift = {m_shift[6:0], d};
            m_bits++;
            if (m_bits == 8) push_ev(EvByte, m_shift, 1'b1, now + Latency);
          end else begin
            push_ev(EvAck, {7'd0, d}, 1'b1, now + Latency);
            m_bits = 0;
          end
        end
      end
      m_scl = s; m_sda = d;
    end
    m_gap += len;
    if (m_busy && m_gap >= int'(ToCycles)) begin
      push_ev(EvTimeout, 8'h00, 1'b0, -1);
      m_busy = 1'b0; m_bits = 0;
    end
  endtask

  task automatic phase(input logic s, input logic d, input int len);
    model_step(s, d, len, cyc);
    sclk = s;
    sdin = d;
    repeat (len) @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    if (!(sclk && sdin)) begin
      phase(1'b0, 1'b1, hl);
      phase(1'b1, 1'b1, hl);
    end
    phase(1'b1, 1'b0, hl);
  endtask

  task automatic do_stop();
    phase(1'b0, 1'b0, hl);
    phase(1'b1, 1'b0, hl);
    phase(1'b1, 1'b1, hl);
  endtask

  task automatic send_bit(input logic b);
    phase(1'b0, b, hl);
    phase(1'b1, b, hl);
  endtask

  task automatic send_byte(input logic [7:0] v, input logic a);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    send_bit(a);
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic chk_ev(input ev_e k);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected %s pulse at cycle %0d: required no pulse", k.name(), cyc);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != k || (e.at >= 0 && e.at != cyc) || bus_busy !== e.busy ||
        (k == EvByte && byte_data !== e.data) || (k == EvAck && ack_bit !== e.data[0])) begin
      errors++;
      $display("FAIL event: got %s data=%h ack=%b busy=%b cycle=%0d, required %s data=%h busy=%b cycle=%0d",
               k.name(), byte_data, ack_bit, bus_busy, cyc, e.kind.name(), e.data, e.busy, e.at);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (start_detect)  chk_ev(EvStart);
      if (rstart_detect) chk_ev(EvRstart);
      if (stop_detect)   chk_ev(EvStop);
      if (timeout)       chk_ev(EvTimeout);
      if (byte_valid)    chk_ev(EvByte);
      if (ack_valid)     chk_ev(EvAck);
    end
  end

  task automatic chk_reset_state();
    chk("reset start_detect", {7'd0, start_detect}, 8'h00);
    chk("reset rstart_detect", {7'd0, rstart_detect}, 8'h00);
    chk("reset stop_detect", {7'd0, stop_detect}, 8'h00);
    chk("reset bus_busy", {7'd0, bus_busy}, 8'h00);
    chk("reset byte_valid", {7'd0, byte_valid}, 8'h00);
    chk("reset byte_data", byte_data, 8'h00);
    chk("reset ack_valid", {7'd0, ack_valid}, 8'h00);
    chk("reset ack_bit", {7'd0, ack_bit}, 8'h01);
    chk("reset timeout", {7'd0, timeout}, 8'h00);
  endtask

  task automatic reset_model();
    m_scl = 1'b1; m_sda = 1'b1; m_busy = 1'b0; m_bits = 0; m_gap = 0; m_shift = '0;
  endtask

  initial begin
    repeat (4) @(negedge clk);
    chk_reset_state();
    @(posedge clk);
    #1 reset = 1'b1;

    // Idle lines: no pulses for 20 cycles.
    phase(1'b1, 1'b1, 20);
    chk("idle bus_busy", {7'd0, bus_busy}, 8'h00);

    // Slow transaction, 10-cycle bus phases.
    hl = 10;
    do_start();
    send_byte(8'hA5, 1'b0);
    do_stop();
    phase(1'b1, 1'b1, 20);
    chk("after stop bus_busy", {7'd0, bus_busy}, 8'h00);
    hl = 6;

    // Partial byte then repeated START, byte with NACK.
    do_start();
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    do_start();
    send_byte(8'h3C, 1'b1);
    do_stop();
    phase(1'b1, 1'b1, 10);

    // Glitches on SDA with SCL high while idle.
    phase(1'b1, 1'b0, 2);
    phase(1'b1, 1'b1, 20);
    phase(1'b1, 1'b0, 3);
    phase(1'b1, 1'b1, 20);

    // Hung SCL after START, then a fresh START.
    do_start();
    phase(1'b0, 1'b0, 40);
    chk("timeout bus_busy", {7'd0, bus_busy}, 8'h00);
    do_start();
    send_byte(8'h5A, 1'b0);
    do_stop();
    phase(1'b1, 1'b1, 10);

    // Reset mid-byte, then a clean byte.
    do_start();
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
    chk("pending events at reset", 8'(exp_q.size()), 8'h00);
    reset = 1'b0;
    sclk = 1'b1;
    sdin = 1'b1;
    reset_model();
    repeat (3) @(negedge clk);
    chk_reset_state();
    @(posedge clk);
    #1 reset = 1'b1;
    phase(1'b1, 1'b1, 10);
    do_start();
    send_byte(8'hFF, 1'b0);
    do_stop();
    phase(1'b1, 1'b1, 10);

    // Both lines toggled together: neither START nor STOP.
    phase(1'b0, 1'b0, hl);
    phase(1'b1, 1'b1, hl);
    phase(1'b1, 1'b1, 10);

    // Randomised transactions.
    for (int t = 0; t < 30; t++) begin
      do_start();
      for (int b = 0; b < int'($urandom_range(1, 3)); b++) begin
        send_byte(8'($urandom), 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 3) == 0) begin
          for (int k = 0; k < int'($urandom_range(1, 7)); k++) send_bit(1'($urandom_range(0, 1)));
          do_start();
        end
      end
      if ($urandom_range(0, 9) == 0) phase(1'b0, 1'b0, 40);
      else do_stop();
      if (sclk && sdin) phase(1'b1, 1'b1, int'($urandom_range(6, 20)));
    end

    phase(sclk, sdin, 30);
    chk("leftover expected events", 8'(exp_q.size()), 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
